// File: rtl/game_pkg.sv
// Shared definitions for the 2048 board engine: move directions, FSM states,
// tile exponent type, LFSR polynomial and small index/score helpers.
package game_pkg;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_SPAWN = 3'd1,
        S_LINE  = 3'd2,
        S_CHECK = 3'd3,
        S_IDLE  = 3'd4
    } state_t;

    // Exponent of a tile at the default width: 0 = empty, k = value 2^k.
    localparam int TILE_W = 4;
    typedef logic [TILE_W-1:0] tile_exp_t;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (right shifting).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        lfsr_next = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // Board index of element j of line k for a move direction on an n x n
    // board. Element 0 sits at the edge the tiles slide towards.
    function automatic int tile_index(input logic [1:0] dir, input int n,
                                      input int k, input int j);
        case (dir)
            DIR_LEFT:  tile_index = k * n + j;
            DIR_RIGHT: tile_index = k * n + (n - 1 - j);
            DIR_UP:    tile_index = j * n + k;
            default:   tile_index = (n - 1 - j) * n + k;
        endcase
    endfunction

    // Score value of a tile with exponent e.
    function automatic logic [31:0] exp_value(input int e);
        exp_value = 32'd1 << e;
    endfunction

endpackage

// File: rtl/line_merge.sv
// Combinational slide-and-merge of one board line towards element 0.
// Produces the new line, a flag per position that holds a merge result,
// the score gained by the line and whether the line changed at all.
module line_merge
    import game_pkg::*;
#(
    parameter int N  = 4,
    parameter int TW = 4
) (
    input  logic [N*TW-1:0] line_in,
    output logic [N*TW-1:0] line_out,
    output logic [N-1:0]    merge_flags,
    output logic [31:0]     score_delta,
    output logic            line_changed
);
    // Top exponent cannot grow further, so equal pairs there stay apart.
    localparam logic [TW-1:0] MAX_EXP = '1;

    // One extra always-empty slot so comp[r+1] never leaves the array.
    logic [TW-1:0] comp [N+1];
    logic [TW-1:0] res;
    int            cnt;
    int            w;
    logic          skip;

    // Compact non-empty tiles, then merge equal pairs from the leading edge;
    // skip ensures a merged tile never takes part in a second merge.
    always_comb begin
        for (int i = 0; i <= N; i++) comp[i] = '0;
        cnt          = 0;
        w            = 0;
        skip         = 1'b0;
        res          = '0;
        line_out     = '0;
        merge_flags  = '0;
        score_delta  = '0;
        for (int i = 0; i < N; i++) begin
            if (line_in[i*TW +: TW] != '0) begin
                comp[cnt] = line_in[i*TW +: TW];
                cnt       = cnt + 1;
            end
        end
        for (int r = 0; r < N; r++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (comp[r] != '0) begin
                if (comp[r+1] == comp[r] && comp[r] != MAX_EXP) begin
                    res            = comp[r] + TW'(1);
                    merge_flags[w] = 1'b1;
                    score_delta    = score_delta + exp_value(int'(res));
                    skip           = 1'b1;
                end else begin
                    res = comp[r];
                end
                line_out[w*TW +: TW] = res;
                w = w + 1;
            end
        end
        line_changed = (line_out != line_in);
    end

endmodule

// File: rtl/game_board_engine.sv
// NxN 2048 board engine: holds tile exponents, runs one move per handshake
// (one line per cycle), spawns a tile from an LFSR-chosen start position and
// then registers win / game-over for the display path.
//
// Handshake: a move transfers on a rising edge where move_valid and
// move_ready are both high; move_valid may be held and is ignored while
// move_ready is low. load_valid is taken on any edge in IDLE, ahead of a move.
module game_board_engine
    import game_pkg::*;
#(
    parameter int          N       = 4,
    parameter int          TW      = 4,
    parameter int          WIN_EXP = 11,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              move_valid,
    input  logic [1:0]        move_dir,
    output logic              move_ready,
    input  logic              load_valid,
    input  logic [N*N*TW-1:0] load_board,
    output logic [N*N*TW-1:0] board,
    output logic [N*N-1:0]    merged,
    output logic [31:0]       score,
    output logic              done,
    output logic              changed,
    output logic              win,
    output logic              game_over
);
    localparam int NT = N * N;
    localparam int KW = $clog2(N);
    localparam int IW = $clog2(NT);
    localparam int CW = $clog2(NT + 1);

    state_t          state, state_d;
    logic [KW-1:0]   k_q;
    logic [1:0]      dir_q;
    logic [15:0]     lfsr_q;
    logic [IW-1:0]   scan_idx;
    logic [CW-1:0]   scan_cnt;
    logic            spawn_more;

    logic [N*TW-1:0] line_in;
    logic [N*TW-1:0] line_out;
    logic [N-1:0]    line_flags;
    logic [31:0]     line_delta;
    logic            line_changed;

    logic            accept_load;
    logic            accept_move;
    logic            line_last;
    logic            moved;
    logic            spawn_hit;
    logic            scan_end;
    logic            start_spawn;
    logic [TW-1:0]   scan_tile;
    logic [TW-1:0]   spawn_exp;
    logic            over_now;
    logic            win_now;

    assign move_ready = (state == S_IDLE) && !game_over;
    assign scan_tile  = board[int'(scan_idx)*TW +: TW];
    assign spawn_exp  = (mode && lfsr_q[2:0] == 3'd0) ? TW'(2) : TW'(1);

    line_merge #(.N(N), .TW(TW)) u_line_merge (
        .line_in      (line_in),
        .line_out     (line_out),
        .merge_flags  (line_flags),
        .score_delta  (line_delta),
        .line_changed (line_changed)
    );

    // Gather line k of the current move into element order.
    always_comb begin
        line_in = '0;
        for (int j = 0; j < N; j++) begin
            line_in[j*TW +: TW] = board[tile_index(dir_q, N, int'(k_q), j)*TW +: TW];
        end
    end

    // Board-wide detection of empty tiles, mergeable neighbours and winning tiles.
    always_comb begin
        over_now = 1'b1;
        win_now  = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                int ri;
                int di;
                ri = (c < N - 1) ? (r * N + c + 1) : (r * N + c);
                di = (r < N - 1) ? ((r + 1) * N + c) : (r * N + c);
                if (board[(r*N+c)*TW +: TW] == '0) over_now = 1'b0;
                if (int'(board[(r*N+c)*TW +: TW]) >= WIN_EXP) win_now = 1'b1;
                if (c < N - 1 && board[(r*N+c)*TW +: TW] == board[ri*TW +: TW]) over_now = 1'b0;
                if (r < N - 1 && board[(r*N+c)*TW +: TW] == board[di*TW +: TW]) over_now = 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_INIT;
        else        state <= state_d;
    end

    // FSM next state and the datapath strobes derived from it.
    always_comb begin
        state_d     = state;
        accept_load = 1'b0;
        accept_move = 1'b0;
        line_last   = 1'b0;
        moved       = changed | line_changed;
        spawn_hit   = 1'b0;
        scan_end    = 1'b0;
        start_spawn = 1'b0;
        case (state)
            S_INIT: begin
                start_spawn = 1'b1;
                state_d     = S_SPAWN;
            end
            S_SPAWN: begin
                spawn_hit = (scan_tile == '0);
                scan_end  = !spawn_hit && (scan_cnt == CW'(NT - 1));
                if (spawn_hit || scan_end) begin
                    start_spawn = spawn_more;
                    state_d     = spawn_more ? S_SPAWN : S_CHECK;
                end
            end
            S_LINE: begin
                line_last = (k_q == KW'(N - 1));
                if (line_last) begin
                    start_spawn = moved;
                    state_d     = moved ? S_SPAWN : S_CHECK;
                end
            end
            S_CHECK: state_d = S_IDLE;
            S_IDLE: begin
                if (load_valid) begin
                    accept_load = 1'b1;
                    state_d     = S_CHECK;
                end else if (move_valid && !game_over) begin
                    accept_move = 1'b1;
                    state_d     = S_LINE;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // Board, score, LFSR, spawn scan and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board      <= '0;
            merged     <= '0;
            score      <= '0;
            done       <= 1'b0;
            changed    <= 1'b0;
            win        <= 1'b0;
            game_over  <= 1'b0;
            lfsr_q     <= SEED;
            k_q        <= '0;
            dir_q      <= DIR_LEFT;
            scan_idx   <= '0;
            scan_cnt   <= '0;
            spawn_more <= 1'b0;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
            done   <= 1'b0;

            if (accept_load) begin
                board   <= load_board;
                merged  <= '0;
                score   <= '0;
                win     <= 1'b0;
                changed <= 1'b0;
            end

            if (accept_move) begin
                dir_q   <= move_dir;
                k_q     <= '0;
                merged  <= '0;
                changed <= 1'b0;
            end

            if (state == S_LINE) begin
                for (int j = 0; j < N; j++) begin
                    board[tile_index(dir_q, N, int'(k_q), j)*TW +: TW] <= line_out[j*TW +: TW];
                    merged[tile_index(dir_q, N, int'(k_q), j)]         <= line_flags[j];
                end
                score   <= score + line_delta;
                changed <= changed | line_changed;
                k_q     <= k_q + KW'(1);
            end

            if (start_spawn) begin
                scan_idx <= IW'(int'(lfsr_q[IW-1:0]) % NT);
                scan_cnt <= '0;
            end else if (state == S_SPAWN) begin
                scan_idx <= (scan_idx == IW'(NT - 1)) ? '0 : scan_idx + IW'(1);
                scan_cnt <= scan_cnt + CW'(1);
            end

            if (spawn_hit) board[int'(scan_idx)*TW +: TW] <= spawn_exp;

            if (state == S_INIT) spawn_more <= 1'b1;
            else if (spawn_hit || scan_end) spawn_more <= 1'b0;

            if (state == S_CHECK) begin
                game_over <= over_now;
                win       <= win | win_now;
                done      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_game_board_engine.sv
// Directed bench for game_board_engine (N=4, TW=4): a vector table of
// load/move/expected-board records plus hand sequences for reset, INIT
// spawns, load priority, game over, win persistence and reset mid-move.
module tb_game_board_engine;
    import game_pkg::*;

    localparam int N  = 4;
    localparam int TW = 4;
    localparam int NT = N * N;
    localparam int BW = NT * TW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode;
    logic          move_valid;
    logic [1:0]    move_dir;
    logic          move_ready;
    logic          load_valid;
    logic [BW-1:0] load_board;
    logic [BW-1:0] board;
    logic [NT-1:0] merged;
    logic [31:0]   score;
    logic          done;
    logic          changed;
    logic          win;
    logic          game_over;

    int total;
    int bad;

    game_board_engine #(.N(N), .TW(TW), .WIN_EXP(11), .SEED(16'hACE1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .move_ready (move_ready),
        .load_valid (load_valid),
        .load_board (load_board),
        .board      (board),
        .merged     (merged),
        .score      (score),
        .done       (done),
        .changed    (changed),
        .win        (win),
        .game_over  (game_over)
    );

    // Clock and a hard stop in case something hangs.
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [BW-1:0] load;
        logic [1:0]    dir;
        logic [BW-1:0] exp_board;
        logic [31:0]   exp_score;
        logic [NT-1:0] exp_merged;
        logic          exp_changed;
        logic          exp_win;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [15:0] row(input int a, input int b, input int c, input int d);
        row = {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic logic [BW-1:0] bd(input logic [15:0] r0, input logic [15:0] r1,
                                         input logic [15:0] r2, input logic [15:0] r3);
        bd = {r3, r2, r1, r0};
    endfunction

    function automatic int count_nz(input logic [BW-1:0] b);
        count_nz = 0;
        for (int i = 0; i < NT; i++) if (b[i*TW +: TW] != '0) count_nz++;
    endfunction

    function automatic int count_val(input logic [BW-1:0] b, input int v);
        count_val = 0;
        for (int i = 0; i < NT; i++) if (int'(b[i*TW +: TW]) == v) count_val++;
    endfunction

    // Tiles differing from the expected board: legal spawns go to spawns,
    // anything else to wrong.
    function automatic void diff_tiles(input logic [BW-1:0] act, input logic [BW-1:0] expb,
                                       input int max_sp, output int spawns, output int wrong);
        spawns = 0;
        wrong  = 0;
        for (int i = 0; i < NT; i++) begin
            int a;
            int e;
            a = int'(act[i*TW +: TW]);
            e = int'(expb[i*TW +: TW]);
            if (a != e) begin
                if (e == 0 && a >= 1 && a <= max_sp) spawns++;
                else wrong++;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic wait_done(input int max_cyc, output int cyc, output bit ok);
        int i;
        ok  = 1'b0;
        cyc = 0;
        i   = 0;
        while (!ok && i < max_cyc) begin
            @(posedge clk);
            #1;
            i++;
            if (done) begin
                ok  = 1'b1;
                cyc = i;
            end
        end
    endtask

    task automatic do_load(input logic [BW-1:0] img, output int cyc, output bit ok);
        @(negedge clk);
        load_board = img;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        wait_done(20, cyc, ok);
    endtask

    task automatic do_move(input logic [1:0] dir, output int cyc, output bit ok);
        @(negedge clk);
        move_dir   = dir;
        move_valid = 1'b1;
        @(posedge clk);
        #1;
        move_valid = 1'b0;
        wait_done(60, cyc, ok);
    endtask

    initial begin
        int            cyc;
        bit            ok;
        int            sp;
        int            wr;
        int            dones;
        logic [BW-1:0] img;
        logic [BW-1:0] chk_img;

        total      = 0;
        bad        = 0;
        rst_n      = 1'b1;
        mode       = 1'b0;
        move_valid = 1'b0;
        move_dir   = DIR_LEFT;
        load_valid = 1'b0;
        load_board = '0;

        vecs[0] = '{bd(row(1,1,1,1), 0, 0, 0), DIR_LEFT,  bd(row(2,2,0,0), 0, 0, 0),
                    32'd8, 16'h0003, 1'b1, 1'b0};
        vecs[1] = '{bd(row(1,1,2,0), 0, 0, 0), DIR_RIGHT, bd(row(0,0,2,2), 0, 0, 0),
                    32'd4, 16'h0004, 1'b1, 1'b0};
        vecs[2] = '{bd(row(1,2,0,0), 0, 0, 0), DIR_LEFT,  bd(row(1,2,0,0), 0, 0, 0),
                    32'd0, 16'h0000, 1'b0, 1'b0};
        vecs[3] = '{bd(row(10,10,0,0), 0, 0, 0), DIR_LEFT, bd(row(11,0,0,0), 0, 0, 0),
                    32'd2048, 16'h0001, 1'b1, 1'b1};
        vecs[4] = '{bd(row(3,0,0,0), row(3,0,0,0), row(3,0,0,0), 0), DIR_UP,
                    bd(row(4,0,0,0), row(3,0,0,0), 0, 0), 32'd16, 16'h0001, 1'b1, 1'b0};
        vecs[5] = '{bd(row(0,2,0,0), 0, row(0,2,0,0), row(0,1,0,0)), DIR_DOWN,
                    bd(0, 0, row(0,3,0,0), row(0,1,0,0)), 32'd8, 16'h0200, 1'b1, 1'b0};
        vecs[6] = '{bd(row(15,15,0,0), 0, 0, 0), DIR_LEFT, bd(row(15,15,0,0), 0, 0, 0),
                    32'd0, 16'h0000, 1'b0, 1'b1};
        vecs[7] = '{bd(0, row(0,15,15,1), 0, 0), DIR_LEFT, bd(0, row(15,15,1,0), 0, 0),
                    32'd0, 16'h0000, 1'b1, 1'b1};
        vecs[8] = '{bd(0, 0, row(2,0,2,2), 0), DIR_RIGHT, bd(0, 0, row(0,0,2,3), 0),
                    32'd8, 16'h0800, 1'b1, 1'b0};

        // Reset values, then INIT places two exp-1 tiles.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_board", board, '0);
        chk("rst_merged", merged, '0);
        chk("rst_score", score, 0);
        chk("rst_flags", {done, changed, win, game_over, move_ready}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_done(100, cyc, ok);
        chk("init_done", ok, 1);
        chk("init_tiles", count_nz(board), 2);
        chk("init_exp1", count_val(board, 1), 2);
        chk("init_ready", move_ready, 1);

        // Table of single moves.
        for (int v = 0; v < 9; v++) begin
            do_load(vecs[v].load, cyc, ok);
            chk($sformatf("v%0d_load_done", v), ok, 1);
            chk($sformatf("v%0d_load_board", v), board, vecs[v].load);
            do_move(vecs[v].dir, cyc, ok);
            chk($sformatf("v%0d_move_done", v), ok, 1);
            if (!vecs[v].exp_changed) begin
                chk($sformatf("v%0d_latency", v), cyc, N + 1);
                chk($sformatf("v%0d_board", v), board, vecs[v].exp_board);
            end else begin
                chk($sformatf("v%0d_lat_range", v), (cyc >= N + 2) && (cyc <= N + 1 + NT), 1);
                diff_tiles(board, vecs[v].exp_board, 1, sp, wr);
                chk($sformatf("v%0d_spawns", v), sp, 1);
                chk($sformatf("v%0d_wrong_tiles", v), wr, 0);
            end
            chk($sformatf("v%0d_score", v), score, vecs[v].exp_score);
            chk($sformatf("v%0d_merged", v), merged, vecs[v].exp_merged);
            chk($sformatf("v%0d_changed", v), changed, vecs[v].exp_changed);
            chk($sformatf("v%0d_win", v), win, vecs[v].exp_win);
            chk($sformatf("v%0d_over", v), game_over, 0);
        end

        // Load wins over a simultaneous move request.
        img = bd(row(1,1,0,0), 0, 0, 0);
        @(negedge clk);
        load_board = img;
        load_valid = 1'b1;
        move_dir   = DIR_LEFT;
        move_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        move_valid = 1'b0;
        wait_done(20, cyc, ok);
        chk("prio_done", ok, 1);
        chk("prio_latency", cyc, 1);
        chk("prio_board", board, img);
        chk("prio_score", score, 0);

        // Full checkerboard: game over, moves ignored, reload clears it.
        chk_img = bd(row(1,2,1,2), row(2,1,2,1), row(1,2,1,2), row(2,1,2,1));
        do_load(chk_img, cyc, ok);
        chk("over_load_done", ok, 1);
        chk("over_flag", game_over, 1);
        chk("over_ready", move_ready, 0);
        dones = 0;
        @(negedge clk);
        move_dir   = DIR_LEFT;
        move_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        move_valid = 1'b0;
        chk("over_no_done", dones, 0);
        chk("over_board_kept", board, chk_img);
        do_load('0, cyc, ok);
        chk("over_clear_done", ok, 1);
        chk("over_cleared", game_over, 0);
        chk("over_ready_back", move_ready, 1);

        // Reaching 2048 sets win, which survives the following move (fun mode).
        do_load(bd(row(10,10,0,0), 0, 0, 0), cyc, ok);
        do_move(DIR_LEFT, cyc, ok);
        chk("win_move_done", ok, 1);
        chk("win_set", win, 1);
        chk("win_score", score, 2048);
        mode = 1'b1;
        do_move(DIR_DOWN, cyc, ok);
        mode = 1'b0;
        chk("win_move2_done", ok, 1);
        chk("win_sticky", win, 1);
        chk("win_score_kept", score, 2048);
        chk("win_changed", changed, 1);
        chk("win_tiles", count_nz(board), 3);
        chk("win_has_11", count_val(board, 11), 1);
        chk("win_fun_spawn", count_val(board, 1) + count_val(board, 2), 2);

        // Reset during LINE k=2 clears everything at once; INIT follows.
        @(negedge clk);
        move_dir   = DIR_RIGHT;
        move_valid = 1'b1;
        @(posedge clk);
        #1;
        move_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_busy", move_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_board", board, '0);
        chk("mid_rst_score", score, 0);
        chk("mid_rst_merged", merged, '0);
        chk("mid_rst_flags", {done, changed, win, game_over, move_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(100, cyc, ok);
        chk("reinit_done", ok, 1);
        chk("reinit_tiles", count_nz(board), 2);
        chk("reinit_exp1", count_val(board, 1), 2);
        chk("reinit_score", score, 0);
        chk("reinit_win", win, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
